fwd_scoreboard: RTL and testbench

Parametrised forwarding and load-use scoreboard for the RV32I pipeline. It holds a shift register of destination-register records for the DEPTH stages after EX (EX/MEM, MEM/WB, ...). From these records it generates per-source forwarding selects for the instruction in EX, plus a load-use stall. With NUM_SRC=2 and DEPTH=2, the select encodings equal forwardmux1_sel_t / forwardmux2_sel_t (0 = id_ex, 1 = ex_mem, 2 = mem_wb). Additional read ports, deeper memory pipelines and longer load latencies are supported through parameters.

---
 rtl/fwd_scoreboard.sv | 138 +++++++++++++
 tb/tb_fwd_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: destination-register scoreboard for the stages after EX.
// Keeps one record per post-EX slot and derives, for every EX source operand,
// which pipeline stage must forward its value. It also raises a load-use stall
// when the youngest producer is a load whose data is not yet available.
// Slot 0 is the youngest record (EX/MEM) and maps to select value 1. Slot s
// maps to select value s+1. Select 0 means the operand comes from ID/EX.

module fwd_scoreboard #(
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 2,
   parameter int LOAD_LAT = 1,
   localparam int SEL_W   = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     freeze_i,
   input  logic                     flush_i,
   input  logic                     ex_valid_i,
   input  logic                     ex_we_i,
   input  logic                     ex_is_load_i,
   input  logic [4:0]               ex_rd_i,
   input  logic [NUM_SRC*5-1:0]     ex_rs_i,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
   output logic                     stall_o,
   output logic [31:0]              stall_cnt_o
);

   // One destination record per post-EX slot.
   typedef struct packed {
      logic       valid;
      logic       we;
      logic       is_load;
      logic [4:0] rd;
   } slot_t;

   // An empty slot. A bubble can never match a source register.
   localparam slot_t BUBBLE = '{valid: 1'b0, we: 1'b0, is_load: 1'b0, rd: 5'd0};

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   // A slot supplies a source only when it really writes a register other
   // than x0 and that register equals the source. Because rd must be nonzero,
   // a source of x0 never matches.
   function automatic logic slot_hit(input slot_t slot, input logic [4:0] rs);
      return slot.valid && slot.we && (slot.rd != 5'd0) && (slot.rd == rs);
   endfunction

   slot_t                slot_q [DEPTH];
   slot_t                slot_d [DEPTH];
   logic [31:0]          stall_cnt_q;
   logic [31:0]          stall_cnt_d;
   logic [SEL_W-1:0]     sel_s [NUM_SRC];
   logic [NUM_SRC-1:0]   load_hit_s;
   logic                 stall_s;

   // Per-source forwarding select. The slots are scanned from oldest to
   // youngest, so a younger match overwrites an older one and the youngest
   // producer wins. The early-load flag is taken from the winning slot only.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         sel_s[i]      = '0;
         load_hit_s[i] = 1'b0;
         for (int s = DEPTH - 1; s >= 0; s--) begin
            if (slot_hit(slot_q[s], ex_rs_i[i*5 +: 5])) begin
               sel_s[i]      = SEL_W'(s + 1);
               load_hit_s[i] = slot_q[s].is_load && (s < LOAD_LAT);
            end else begin
               sel_s[i]      = sel_s[i];
               load_hit_s[i] = load_hit_s[i];
            end
         end
      end
   end

   // Load-use stall. A squashed or empty EX stage never stalls.
   always_comb begin
      stall_s = 1'b0;
      if (ex_valid_i && !flush_i) begin
         stall_s = |load_hit_s;
      end else begin
         stall_s = 1'b0;
      end
   end

   // Pack the per-source selects into the flat output bus.
   always_comb begin
      fwd_sel_o = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         fwd_sel_o[i*SEL_W +: SEL_W] = sel_s[i];
      end
   end

   // Next state. A freeze holds the slots and the counter. Otherwise the
   // records shift one slot older and slot 0 takes either the EX record or a
   // bubble when EX is squashed or held by a stall.
   always_comb begin
      slot_d      = slot_q;
      stall_cnt_d = stall_cnt_q;
      if (!freeze_i) begin
         for (int s = DEPTH - 1; s >= 1; s--) begin
            slot_d[s] = slot_q[s-1];
         end
         if (flush_i || stall_s) begin
            slot_d[0] = BUBBLE;
         end else begin
            slot_d[0].valid   = ex_valid_i;
            slot_d[0].we      = ex_we_i;
            slot_d[0].is_load = ex_is_load_i;
            slot_d[0].rd      = ex_rd_i;
         end
         if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
      end else begin
         slot_d      = slot_q;
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State register. Reset takes priority over freeze.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < DEPTH; s++) begin
            slot_q[s] <= BUBBLE;
         end
         stall_cnt_q <= 32'd0;
      end else begin
         slot_q      <= slot_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_o     = stall_s;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard. It drives two instances from the same
// input stream. The first uses the default parameters. The second uses
// NUM_SRC=3, DEPTH=4, LOAD_LAT=2. A queue-based model predicts each cycle's
// outputs, and a monitor compares them on the falling edge.
module tb_fwd_scoreboard;

   typedef struct packed {
      logic       v;
      logic       we;
      logic       ld;
      logic [4:0] rd;
   } rec_t;

   typedef struct packed {
      logic [15:0] sel;
      logic        stall;
      logic [31:0] cnt;
   } exp_t;

   localparam rec_t NOREC = '{v: 1'b0, we: 1'b0, ld: 1'b0, rd: 5'd0};

   logic        clk = 1'b0;
   logic        rst, freeze, flush, ex_valid, ex_we, ex_ld;
   logic [4:0]  ex_rd;
   logic [14:0] ex_rs;
   logic [3:0]  sel1;
   logic [8:0]  sel2;
   logic        stall1, stall2;
   logic [31:0] cnt1, cnt2;

   // Values staged for the next cycle.
   logic        n_rst = 1'b1, n_freeze = 1'b0, n_flush = 1'b0, n_force = 1'b0;
   rec_t        n_rec = NOREC;
   logic [4:0]  n_rs [3] = '{5'd0, 5'd0, 5'd0};

   // Reference model: the records of recent instructions, newest first.
   rec_t        hist [2][$];
   logic [31:0] mcnt [2];
   bit          known [2];
   exp_t        eq [2][$];
   int          DEP [2] = '{2, 4};
   int          NS  [2] = '{2, 3};
   int          LL  [2] = '{1, 2};
   int          SW  [2] = '{2, 3};

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fwd_scoreboard dut1 (
      .clk(clk), .rst(rst), .freeze_i(freeze), .flush_i(flush),
      .ex_valid_i(ex_valid), .ex_we_i(ex_we), .ex_is_load_i(ex_ld),
      .ex_rd_i(ex_rd), .ex_rs_i(ex_rs[9:0]), .fwd_sel_o(sel1),
      .stall_o(stall1), .stall_cnt_o(cnt1)
   );

   fwd_scoreboard #(.NUM_SRC(3), .DEPTH(4), .LOAD_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .freeze_i(freeze), .flush_i(flush),
      .ex_valid_i(ex_valid), .ex_we_i(ex_we), .ex_is_load_i(ex_ld),
      .ex_rd_i(ex_rd), .ex_rs_i(ex_rs), .fwd_sel_o(sel2),
      .stall_o(stall2), .stall_cnt_o(cnt2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
      end
   endtask

   // Apply the staged inputs, predict the outputs, then advance the model.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (n_force) begin
         force dut2.stall_cnt_q = 32'hFFFF_FFFF;
         #1;
         release dut2.stall_cnt_q;
         mcnt[1] = 32'hFFFF_FFFF;
         n_force = 1'b0;
      end
      rst      = n_rst;
      freeze   = n_freeze;
      flush    = n_flush;
      ex_valid = n_rec.v;
      ex_we    = n_rec.we;
      ex_ld    = n_rec.ld;
      ex_rd    = n_rec.rd;
      ex_rs    = {n_rs[2], n_rs[1], n_rs[0]};
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         bit   early;
         e.sel = 16'd0;
         early = 1'b0;
         for (int i = 0; i < NS[k]; i++) begin
            // Find the most recent instruction that writes this source.
            for (int d = 0; d < DEP[k]; d++) begin
               rec_t h;
               h = hist[k][d];
               if (h.v && h.we && h.rd != 5'd0 && h.rd == n_rs[i]) begin
                  e.sel = e.sel | (16'(d + 1) << (i * SW[k]));
                  if (h.ld && d < LL[k]) early = 1'b1;
                  break;
               end
            end
         end
         e.stall = n_rec.v && !n_flush && early;
         e.cnt   = mcnt[k];
         if (known[k]) eq[k].push_back(e);
         if (n_rst) begin
            hist[k].delete();
            for (int d = 0; d < DEP[k]; d++) hist[k].push_back(NOREC);
            mcnt[k]  = 32'd0;
            known[k] = 1'b1;
         end else if (!n_freeze) begin
            hist[k].push_front((n_flush || e.stall) ? NOREC : n_rec);
            void'(hist[k].pop_back());
            if (e.stall && mcnt[k] != 32'hFFFF_FFFF) mcnt[k] = mcnt[k] + 32'd1;
         end
      end
   endtask

   task automatic ins(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
      n_rec = '{v: v, we: we, ld: ld, rd: rd};
      n_rs  = '{r0, r1, r2};
      cyc();
   endtask

   // Monitor: the outputs are meaningful every cycle, so one prediction is
   // consumed per falling edge for each instance.
   always @(negedge clk) begin
      exp_t e;
      if (eq[0].size() > 0) begin
         e = eq[0].pop_front();
         chk("d1_sel",   {28'd0, sel1},  {16'd0, e.sel});
         chk("d1_stall", {31'd0, stall1}, {31'd0, e.stall});
         chk("d1_cnt",   cnt1, e.cnt);
      end
      if (eq[1].size() > 0) begin
         e = eq[1].pop_front();
         chk("d2_sel",   {23'd0, sel2},  {16'd0, e.sel});
         chk("d2_stall", {31'd0, stall2}, {31'd0, e.stall});
         chk("d2_cnt",   cnt2, e.cnt);
      end
   end

   // Guard against a hung run.
   initial begin
      #2000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // Stimulus: directed scenarios first, then a randomized run.
   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int d = 0; d < DEP[k]; d++) hist[k].push_back(NOREC);
         mcnt[k]  = 32'd0;
         known[k] = 1'b0;
      end
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_we = 1'b0;
      ex_ld = 1'b0; ex_rd = 5'd0; ex_rs = 15'd0;
      n_rst = 1'b1;
      ins(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      ins(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      n_rst = 1'b0;
      // Post-reset outputs: all selects zero, no stall, counter zero.
      ins(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd6, 5'd7);
      // Producer, then consumers at distance 1 and 2.
      ins(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2, 5'd0);
      ins(1'b1, 1'b1, 1'b0, 5'd8, 5'd5, 5'd6, 5'd0);
      ins(1'b1, 1'b1, 1'b0, 5'd9, 5'd5, 5'd0, 5'd0);
      // Two producers of x7, then the consumer picks the younger one.
      ins(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 5'd0);
      ins(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 5'd0);
      ins(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 5'd7);
      // Load-use: one stall, then the held consumer selects 2.
      ins(1'b1, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 5'd0);
      ins(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd0, 5'd0);
      ins(1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd0, 5'd0);
      // Load-use with freeze held for 3 cycles during the stall.
      ins(1'b1, 1'b1, 1'b1, 5'd11, 5'd0, 5'd0, 5'd0);
      n_freeze = 1'b1;
      repeat (3) ins(1'b1, 1'b1, 1'b0, 5'd12, 5'd11, 5'd0, 5'd0);
      n_freeze = 1'b0;
      repeat (2) ins(1'b1, 1'b1, 1'b0, 5'd12, 5'd11, 5'd0, 5'd0);
      // Producer and consumer of x0.
      ins(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      ins(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      // Flush together with a load-use condition.
      ins(1'b1, 1'b1, 1'b1, 5'd13, 5'd0, 5'd0, 5'd0);
      n_flush = 1'b1;
      ins(1'b1, 1'b1, 1'b0, 5'd14, 5'd13, 5'd0, 5'd0);
      n_flush = 1'b0;
      ins(1'b1, 1'b1, 1'b0, 5'd14, 5'd0, 5'd13, 5'd13);
      // Load at increasing distances from its consumer on source 2.
      for (int gap = 0; gap < 4; gap++) begin
         ins(1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 5'd0);
         repeat (gap) ins(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
         repeat (3) ins(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd10);
      end
      // Counter saturation on the second instance.
      n_force = 1'b1;
      ins(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      ins(1'b1, 1'b1, 1'b1, 5'd15, 5'd0, 5'd0, 5'd0);
      repeat (3) ins(1'b1, 1'b0, 1'b0, 5'd0, 5'd15, 5'd15, 5'd15);
      // Reset in the middle of a stall during a freeze.
      ins(1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 5'd0);
      n_freeze = 1'b1;
      ins(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 5'd0);
      n_rst = 1'b1;
      ins(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 5'd0);
      n_rst = 1'b0; n_freeze = 1'b0;
      ins(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 5'd0);
      // Randomized traffic over a small register range to force many hits.
      for (int c = 0; c < 2000; c++) begin
         n_rst    = ($urandom % 300) == 0;
         n_freeze = ($urandom % 8) == 0;
         n_flush  = ($urandom % 10) == 0;
         ins(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
             5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8));
      end
      n_rst = 1'b0; n_freeze = 1'b0; n_flush = 1'b0;
      ins(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      #1;
      chk("d1_queue_drained", eq[0].size(), 32'd0);
      chk("d2_queue_drained", eq[1].size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
